// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Synchronises raw reset release, holds, then releases NUM_OUTS domains in turn.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int NUM_OUTS       = 3,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst_req,
  output logic [NUM_OUTS-1:0] rst_out_n,
  output logic                seq_done,
  output logic                busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "reset_sequencer: SYNC_STAGES must be 2..4");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $fatal(1, "reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (NUM_OUTS < 1 || NUM_OUTS > 8) begin : g_bad_outs
    $fatal(1, "reset_sequencer: NUM_OUTS must be 1..8");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $fatal(1, "reset_sequencer: STAGGER_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 30 ||
      HOLD_CYCLES > (1 << CNT_W) - 1 || STAGGER_CYCLES > (1 << CNT_W) - 1) begin : g_bad_cnt
    $fatal(1, "reset_sequencer: CNT_W too narrow for HOLD_CYCLES/STAGGER_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_OUTS-1:0] FIRST_REL    = NUM_OUTS'(1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [NUM_OUTS-1:0]   out_nxt;
  logic [NUM_OUTS-1:0]   rel_shift;
  logic [SYNC_STAGES-1:0] sync;
  logic                  sync_ok;

  // Reset assertion is asynchronous; release only ever comes through the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RESET;
      cnt       <= '0;
      rst_out_n <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_out_n <= out_nxt;
    end
  end

  // Releases are contiguous from bit 0, so the next one is a shift-in of a 1.
  assign rel_shift = NUM_OUTS'({rst_out_n, 1'b1});

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = rst_out_n;
    unique case (state)
      ST_RESET: begin
        if (sync_ok) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (soft_rst_req) begin
          cnt_nxt = '0;
          out_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          out_nxt   = FIRST_REL;
          state_nxt = (&FIRST_REL) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (soft_rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          out_nxt   = '0;
        end else if (cnt == STAGGER_LAST) begin
          cnt_nxt = '0;
          out_nxt = rel_shift;
          if (&rel_shift) begin
            state_nxt = ST_RUN;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (soft_rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          out_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
        out_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == ST_HOLD) || (state == ST_RELEASE);
  assign seq_done = (state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Directed bench for reset_sequencer (defaults plus a NUM_OUTS=1 instance).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       soft2 = 1'b0;
  logic [2:0] rst_out_n;
  logic       seq_done;
  logic       busy;
  logic [0:0] rst_out_n2;
  logic       seq_done2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .rst_out_n    (rst_out_n),
    .seq_done     (seq_done),
    .busy         (busy)
  );

  reset_sequencer #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (1),
    .NUM_OUTS    (1)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft2),
    .rst_out_n    (rst_out_n2),
    .seq_done     (seq_done2),
    .busy         (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // h counts edges since the HOLD-entry edge (h=0: HOLD just entered, cnt=0).
  task automatic check_seq(input int h0, input int n, input bit chk1);
    logic [2:0] e_out;
    for (int i = 0; i < n; i++) begin
      int h;
      h = h0 + i;
      @(posedge clk);
      #1;
      e_out = (h >= 24) ? 3'b111 : (h >= 20) ? 3'b011 : (h >= 16) ? 3'b001 : 3'b000;
      check($sformatf("out h=%0d", h), 32'(rst_out_n), 32'(e_out));
      check($sformatf("done h=%0d", h), 32'(seq_done), 32'(h >= 24));
      check($sformatf("busy h=%0d", h), 32'(busy), 32'(h >= 0 && h < 24));
      if (chk1) begin
        check($sformatf("n1 out h=%0d", h), 32'(rst_out_n2), 32'(h >= 1));
        check($sformatf("n1 done h=%0d", h), 32'(seq_done2), 32'(h >= 1));
        check($sformatf("n1 busy h=%0d", h), 32'(busy2), 32'(h == 0));
      end
    end
  endtask

  initial begin
    // Reset held for two edges, released mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    check("rst out", 32'(rst_out_n), 32'h0);
    check("rst done", 32'(seq_done), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst n1 out", 32'(rst_out_n2), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_seq(-2, 30, 1'b1);

    // Mid-sequence asynchronous reset at edge 21.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_seq(-2, 21, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async out", 32'(rst_out_n), 32'h0);
    check("async done", 32'(seq_done), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async n1 out", 32'(rst_out_n2), 32'h0);
    check("async n1 done", 32'(seq_done2), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_seq(-2, 28, 1'b1);

    // One-cycle soft reset from RUN.
    @(negedge clk);
    soft_rst_req = 1'b1;
    check_seq(0, 1, 1'b0);
    soft_rst_req = 1'b0;
    check_seq(1, 26, 1'b0);

    // Soft reset held for five edges extends HOLD.
    @(negedge clk);
    soft_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) check_seq(0, 1, 1'b0);
    soft_rst_req = 1'b0;
    check_seq(1, 26, 1'b0);

    // Soft reset coinciding with the bit-1 release edge wins.
    @(negedge clk);
    soft_rst_req = 1'b1;
    check_seq(0, 1, 1'b0);
    soft_rst_req = 1'b0;
    check_seq(1, 19, 1'b0);
    soft_rst_req = 1'b1;
    check_seq(0, 1, 1'b0);
    soft_rst_req = 1'b0;
    check_seq(1, 26, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
